// File: rtl/opq_credit_arbiter.sv
// Credit-based round-robin arbiter for operand queues sharing one VRF read port.
// A queue is granted only while it holds a credit (a free data-buffer slot);
// credits return as elements leave the queue, and a flush refills them.
module opq_credit_arbiter #(
  parameter int NrReq       = 9,
  parameter int CreditDepth = 5,
  parameter int CntWidth    = $clog2(CreditDepth + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NrReq-1:0]          req_i,
  input  logic                      stall_i,
  input  logic [NrReq-1:0]          credit_ret_i,
  input  logic [NrReq-1:0]          flush_i,
  output logic [NrReq-1:0]          gnt_o,
  output logic [NrReq-1:0]          issued_o,
  output logic [NrReq*CntWidth-1:0] credits_o,
  output logic                      idle_o
);

  localparam int PtrWidth = (NrReq > 1) ? $clog2(NrReq) : 1;
  localparam logic [CntWidth-1:0] FullCredit = CntWidth'(CreditDepth);

  logic [PtrWidth-1:0] rr_ptr_reg;
  logic [PtrWidth-1:0] rr_ptr_next;
  logic [NrReq-1:0]    issued_reg;
  logic                overflow_err_reg;   // sticky debug flag: return seen at full credit

  logic [NrReq-1:0]    eligible;
  logic [NrReq-1:0]    gnt;
  logic [NrReq-1:0]    credit_full;
  logic [NrReq-1:0]    overflow_hit;

  logic [PtrWidth:0]   sum;
  logic [PtrWidth-1:0] idx;
  logic                found;

  // Per-queue credit counters; each lives in its own generate scope.
  for (genvar gi = 0; gi < NrReq; gi++) begin : gen_queue
    logic [CntWidth-1:0] credit_reg;
    logic [CntWidth-1:0] credit_next;

    // A flushed queue cannot be granted this cycle: its buffer is being refilled.
    assign eligible[gi]     = req_i[gi] & (credit_reg != '0) & ~flush_i[gi];
    assign credit_full[gi]  = (credit_reg == FullCredit);
    assign overflow_hit[gi] = credit_ret_i[gi] & ~gnt[gi] & ~flush_i[gi] & credit_full[gi];
    assign credits_o[gi*CntWidth +: CntWidth] = credit_reg;

    // Next credit: flush refills; grant and return in one cycle cancel out.
    always_comb begin
      credit_next = credit_reg;
      if (flush_i[gi]) begin
        credit_next = FullCredit;
      end else if (credit_ret_i[gi] && !gnt[gi]) begin
        if (!credit_full[gi]) begin
          credit_next = credit_reg + CntWidth'(1);
        end
      end else if (gnt[gi] && !credit_ret_i[gi]) begin
        credit_next = credit_reg - CntWidth'(1);
      end
    end

    // Credit register, refilled on reset.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        credit_reg <= FullCredit;
      end else begin
        credit_reg <= credit_next;
      end
    end
  end

  // Round-robin pick: scan from rr_ptr upward, wrapping, first eligible wins.
  always_comb begin
    gnt         = '0;
    rr_ptr_next = rr_ptr_reg;
    found       = 1'b0;
    sum         = '0;
    idx         = '0;
    if (!stall_i) begin
      for (int off = 0; off < NrReq; off++) begin
        sum = {1'b0, rr_ptr_reg} + (PtrWidth + 1)'(off);
        if (sum >= (PtrWidth + 1)'(NrReq)) begin
          sum = sum - (PtrWidth + 1)'(NrReq);
        end
        idx = sum[PtrWidth-1:0];
        if (!found && eligible[idx]) begin
          found       = 1'b1;
          gnt[idx]    = 1'b1;
          rr_ptr_next = (idx == PtrWidth'(NrReq - 1)) ? '0 : idx + PtrWidth'(1);
        end
      end
    end
  end

  // Shared state: pointer, issued pulse register and the sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_reg       <= '0;
      issued_reg       <= '0;
      overflow_err_reg <= 1'b0;
    end else begin
      rr_ptr_reg       <= rr_ptr_next;
      issued_reg       <= gnt;
      overflow_err_reg <= overflow_err_reg | (|overflow_hit);
    end
  end

  // Once raised, the overflow flag holds until reset.
  overflow_sticky_a : assert property (@(posedge clk_i)
    (overflow_err_reg && !rst_i) |=> overflow_err_reg);

  assign gnt_o    = gnt;
  assign issued_o = issued_reg;
  assign idle_o   = (&credit_full) & ~(|issued_reg);

endmodule

// File: tb/tb_opq_credit_arbiter.sv
// Scenario bench for opq_credit_arbiter: expected issued_o pulses are queued
// when a grant is expected and compared one cycle later.
module tb_opq_credit_arbiter;

  localparam int N  = 9;
  localparam int D  = 5;
  localparam int CW = $clog2(D + 1);
  localparam logic [CW-1:0] FULL = CW'(D);

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N-1:0]      req_i;
  logic              stall_i;
  logic [N-1:0]      credit_ret_i;
  logic [N-1:0]      flush_i;
  logic [N-1:0]      gnt_o;
  logic [N-1:0]      issued_o;
  logic [N*CW-1:0]   credits_o;
  logic              idle_o;

  logic [N-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  opq_credit_arbiter #(.NrReq(N), .CreditDepth(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .stall_i(stall_i),
    .credit_ret_i(credit_ret_i), .flush_i(flush_i), .gnt_o(gnt_o),
    .issued_o(issued_o), .credits_o(credits_o), .idle_o(idle_o)
  );

  // Apply reset with quiet inputs; leaves time at posedge+1.
  task automatic do_reset;
    rst_i = 1'b1; req_i = '0; stall_i = 1'b0; credit_ret_i = '0; flush_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst_i = 1'b1; req_i = '1; stall_i = 1'b0; credit_ret_i = '0; flush_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0; req_i = '0;
    exp_q.delete();
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (credits_o[i*CW +: CW] !== FULL)
        $display("FAIL reset_credit[%0d]: actual %0d required %0d", i, credits_o[i*CW +: CW], FULL);
      else passed++;
    end
    checks++;
    if (issued_o !== '0) $display("FAIL reset_issued: actual %h required 0", issued_o); else passed++;
    checks++;
    if (idle_o !== 1'b1) $display("FAIL reset_idle: actual %b required 1", idle_o); else passed++;
    checks++;
    if (gnt_o !== '0) $display("FAIL reset_gnt_noreq: actual %h required 0", gnt_o); else passed++;
    req_i = 9'h008;
    #1;
    checks++;
    if (gnt_o !== 9'h008) $display("FAIL reset_first_grant: actual %h required 008", gnt_o); else passed++;
    req_i = '0;
    $display("test_reset done");
  endtask

  task automatic test_rotate;
    logic [N-1:0] e;
    do_reset();
    req_i = '1;
    for (int c = 0; c < 45; c++) begin
      #1;
      e = N'(1) << (c % N);
      checks++;
      if (gnt_o !== e) $display("FAIL rotate_gnt c=%0d: actual %h required %h", c, gnt_o, e); else passed++;
      exp_q.push_back(e);
      @(posedge clk_i); #1;
      checks++;
      if (exp_q.size() == 0) $display("FAIL rotate_issued: queue empty, actual %h", issued_o);
      else begin
        e = exp_q.pop_front();
        if (issued_o !== e) $display("FAIL rotate_issued c=%0d: actual %h required %h", c, issued_o, e);
        else passed++;
      end
    end
    #1;
    checks++;
    if (gnt_o !== '0) $display("FAIL rotate_drained_gnt: actual %h required 0", gnt_o); else passed++;
    checks++;
    if (idle_o !== 1'b0) $display("FAIL rotate_idle: actual %b required 0", idle_o); else passed++;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (credits_o[i*CW +: CW] !== '0)
        $display("FAIL rotate_credit[%0d]: actual %0d required 0", i, credits_o[i*CW +: CW]);
      else passed++;
    end
    req_i = '0;
    $display("test_rotate done");
  endtask

  task automatic test_single;
    logic [N-1:0] ret_tab [9] = '{9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h004, 9'h0, 9'h0};
    logic [N-1:0] gnt_tab [9] = '{9'h004, 9'h004, 9'h004, 9'h004, 9'h004, 9'h0, 9'h0, 9'h004, 9'h0};
    logic [N-1:0] e;
    do_reset();
    req_i = 9'h004;
    for (int c = 0; c < 9; c++) begin
      credit_ret_i = ret_tab[c];
      #1;
      checks++;
      if (gnt_o !== gnt_tab[c]) $display("FAIL single_gnt c=%0d: actual %h required %h", c, gnt_o, gnt_tab[c]);
      else passed++;
      exp_q.push_back(gnt_tab[c]);
      @(posedge clk_i); #1;
      checks++;
      if (exp_q.size() == 0) $display("FAIL single_issued: queue empty, actual %h", issued_o);
      else begin
        e = exp_q.pop_front();
        if (issued_o !== e) $display("FAIL single_issued c=%0d: actual %h required %h", c, issued_o, e);
        else passed++;
        $display("single c=%0d issued=%h", c, issued_o);
      end
    end
    checks++;
    if (credits_o[2*CW +: CW] !== '0) $display("FAIL single_credit: actual %0d required 0", credits_o[2*CW +: CW]);
    else passed++;
    req_i = '0; credit_ret_i = '0;
  endtask

  task automatic test_simul;
    logic [N-1:0] e;
    do_reset();
    req_i = 9'h008;
    for (int c = 0; c < 6; c++) begin
      credit_ret_i = (c >= 4) ? 9'h008 : 9'h000;
      #1;
      checks++;
      if (gnt_o !== 9'h008) $display("FAIL simul_gnt c=%0d: actual %h required 008", c, gnt_o); else passed++;
      exp_q.push_back(9'h008);
      @(posedge clk_i); #1;
      checks++;
      if (exp_q.size() == 0) $display("FAIL simul_issued: queue empty, actual %h", issued_o);
      else begin
        e = exp_q.pop_front();
        if (issued_o !== e) $display("FAIL simul_issued c=%0d: actual %h required %h", c, issued_o, e);
        else passed++;
      end
      if (c >= 3) begin
        checks++;
        if (credits_o[3*CW +: CW] !== CW'(1))
          $display("FAIL simul_credit c=%0d: actual %0d required 1", c, credits_o[3*CW +: CW]);
        else passed++;
      end
    end
    req_i = '0; credit_ret_i = '0;
    $display("test_simul done");
  endtask

  task automatic test_stall;
    logic [N-1:0] seq [3] = '{9'h001, 9'h010, 9'h001};
    logic [N-1:0] e;
    do_reset();
    req_i = 9'h011;
    for (int c = 0; c < 6; c++) begin
      stall_i = (c < 3);
      e = (c < 3) ? 9'h000 : seq[c-3];
      #1;
      checks++;
      if (gnt_o !== e) $display("FAIL stall_gnt c=%0d: actual %h required %h", c, gnt_o, e); else passed++;
      exp_q.push_back(e);
      @(posedge clk_i); #1;
      checks++;
      if (exp_q.size() == 0) $display("FAIL stall_issued: queue empty, actual %h", issued_o);
      else begin
        e = exp_q.pop_front();
        if (issued_o !== e) $display("FAIL stall_issued c=%0d: actual %h required %h", c, issued_o, e);
        else passed++;
      end
    end
    req_i = '0; stall_i = 1'b0;
    $display("test_stall done");
  endtask

  task automatic test_flush;
    logic [N-1:0] e;
    do_reset();
    req_i = 9'h020;
    for (int c = 0; c < 7; c++) begin
      flush_i = (c == 5) ? 9'h020 : 9'h000;
      e = (c == 5) ? 9'h000 : 9'h020;
      #1;
      checks++;
      if (gnt_o !== e) $display("FAIL flush_gnt c=%0d: actual %h required %h", c, gnt_o, e); else passed++;
      if (c == 5) begin
        checks++;
        if (issued_o !== 9'h020) $display("FAIL flush_keeps_issued: actual %h required 020", issued_o);
        else passed++;
      end
      exp_q.push_back(e);
      @(posedge clk_i); #1;
      checks++;
      if (exp_q.size() == 0) $display("FAIL flush_issued: queue empty, actual %h", issued_o);
      else begin
        e = exp_q.pop_front();
        if (issued_o !== e) $display("FAIL flush_issued c=%0d: actual %h required %h", c, issued_o, e);
        else passed++;
      end
      if (c == 5) begin
        checks++;
        if (credits_o[5*CW +: CW] !== FULL)
          $display("FAIL flush_credit: actual %0d required %0d", credits_o[5*CW +: CW], FULL);
        else passed++;
      end
    end
    req_i = '0; flush_i = '0;
    $display("test_flush done");
  endtask

  task automatic test_overflow_reset;
    logic [N-1:0] e;
    do_reset();
    credit_ret_i = 9'h002;
    @(posedge clk_i); #1;
    credit_ret_i = '0;
    checks++;
    if (credits_o[1*CW +: CW] !== FULL) $display("FAIL ovf_credit: actual %0d required %0d", credits_o[1*CW +: CW], FULL);
    else passed++;
    checks++;
    if (dut.overflow_err_reg !== 1'b1) $display("FAIL ovf_flag: actual %b required 1", dut.overflow_err_reg);
    else passed++;
    req_i = '1;
    for (int c = 0; c < 3; c++) begin
      e = N'(1) << c;
      exp_q.push_back(e);
      @(posedge clk_i); #1;
      checks++;
      if (exp_q.size() == 0) $display("FAIL ovf_issued: queue empty, actual %h", issued_o);
      else begin
        e = exp_q.pop_front();
        if (issued_o !== e) $display("FAIL ovf_issued c=%0d: actual %h required %h", c, issued_o, e);
        else passed++;
      end
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    checks++;
    if (issued_o !== '0) $display("FAIL midreset_issued: actual %h required 0", issued_o); else passed++;
    checks++;
    if (dut.overflow_err_reg !== 1'b0) $display("FAIL midreset_flag: actual %b required 0", dut.overflow_err_reg);
    else passed++;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (credits_o[i*CW +: CW] !== FULL)
        $display("FAIL midreset_credit[%0d]: actual %0d required %0d", i, credits_o[i*CW +: CW], FULL);
      else passed++;
    end
    #1;
    checks++;
    if (gnt_o !== 9'h001) $display("FAIL midreset_ptr: actual %h required 001", gnt_o); else passed++;
    exp_q.push_back(9'h001);
    @(posedge clk_i); #1;
    checks++;
    if (exp_q.size() == 0) $display("FAIL midreset_issue: queue empty, actual %h", issued_o);
    else begin
      e = exp_q.pop_front();
      if (issued_o !== e) $display("FAIL midreset_issue: actual %h required %h", issued_o, e);
      else passed++;
    end
    req_i = '0;
    $display("test_overflow_reset done");
  endtask

  initial begin
    rst_i = 1'b1; req_i = '0; stall_i = 1'b0; credit_ret_i = '0; flush_i = '0;
    test_reset();
    test_rotate();
    test_single();
    test_simul();
    test_stall();
    test_flush();
    test_overflow_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/opq_credit_arbiter.md
OPQ_CREDIT_ARBITER -- requirements
Module: opq_credit_arbiter

Interface
REQ-001 Parameter NrReq, default 9, number of operand-queue requesters sharing one VRF read port.
REQ-002 Parameter CreditDepth, default 5, data-buffer depth of each operand queue and initial credit count; legal range 1..15.
REQ-003 Parameter CntWidth, default $clog2(CreditDepth+1), credit counter width, derived, not overridden.
REQ-004 clk_i  input  1  clock; single clock domain, all state on the rising edge.
REQ-005 rst_i  input  1  reset; synchronous, active-high.
REQ-006 req_i  input  NrReq  per-queue read request from the operand requester.
REQ-007 stall_i  input  1  VRF bank busy; blocks all grants this cycle.
REQ-008 credit_ret_i  input  NrReq  per-queue pulse, one element consumed at the queue output (valid&ready).
REQ-009 flush_i  input  NrReq  per-queue flush; restores that queue's credits.
REQ-010 gnt_o  output  NrReq  one-hot or zero grant, combinational, same cycle as the request.
REQ-011 issued_o  output  NrReq  registered copy of gnt_o, one cycle later; drives operand_issued to the queue.
REQ-012 credits_o  output  NrReq*CntWidth  current credit count per queue.
REQ-013 idle_o  output  1  high when all credits are full and issued_o is zero.

Function
REQ-014 Each queue has a credit counter credit[i]; a grant to queue i requires req_i[i]=1 and credit[i]>0.
REQ-015 Eligible set = req_i & (credit>0) & ~flush_i; when stall_i=1 or the eligible set is empty, gnt_o=0.
REQ-016 Selection is round-robin: search starts at rr_ptr and wraps modulo NrReq; the first eligible index wins.
REQ-017 On a grant to index k, rr_ptr becomes (k+1) mod NrReq on the next edge; with no grant, rr_ptr holds.
REQ-018 At most one gnt_o bit is set per cycle.
REQ-019 Credit update per cycle: credit[i] += credit_ret_i[i] - gnt_o[i]; a simultaneous grant and return leaves the count unchanged.
REQ-020 Return while credit[i]=CreditDepth: the counter saturates at CreditDepth, and the sticky overflow_err flag (debug, internal) sets.
REQ-021 A grant never occurs at credit[i]=0, so there is no underflow path; a return in the same cycle as credit=0 makes the queue eligible only from the next cycle.
REQ-022 flush_i[i]=1 sets credit[i]=CreditDepth on the next edge, masks gnt_o[i] in that cycle, and overrides credit_ret_i[i].
REQ-023 issued_o[i] <= gnt_o[i] every cycle; latency from request to issued is exactly 1 cycle when granted.
REQ-024 A flush on queue i in cycle t does not suppress an issued_o[i] pulse already registered from cycle t-1.
REQ-025 credits_o is the registered counter value, not a bypassed value.
REQ-026 idle_o is a combinational function of registered state only.

Reset
REQ-027 While rst_i=1 at an edge, every credit[i] becomes CreditDepth, rr_ptr becomes 0, issued_o becomes 0, and overflow_err clears.
REQ-028 During and immediately after reset, gnt_o follows the reset state, so any requester with req_i=1 is grantable in the first cycle after reset.
REQ-029 Reset asserted mid-operation discards in-flight issued pulses; no issued_o is produced in the cycle after reset.

Verification
REQ-030 Reset, then req_i=9'h1FF held with no returns, CreditDepth=5 -> grants rotate 0,1,...,8,0,...; after 45 cycles all credits_o=0, gnt_o=0, and idle_o=0.
REQ-031 req_i[2]=1 only, no returns -> 5 consecutive grants with issued_o[2] pulses at cycles 1..5, then gnt_o=0; one credit_ret_i[2] pulse -> exactly one further grant on the next cycle.
REQ-032 credit[3]=1, req_i[3]=1 and credit_ret_i[3]=1 in the same cycle -> gnt_o[3]=1, and credit[3] stays 1 afterwards.
REQ-033 stall_i=1 for 3 cycles with req_i=9'h011 -> gnt_o=0 and rr_ptr unchanged; after stall_i drops, a grant goes to index 0 (ptr=0), then index 4.
REQ-034 credit[5]=0, flush_i[5]=1 with req_i[5]=1 -> no grant that cycle; credits_o[5]=5 next cycle and a grant follows.
REQ-035 credit_ret_i[1] at credit[1]=5 -> credit stays 5 and overflow_err=1; assert rst_i mid-stream -> all credits=5, rr_ptr=0, issued_o=0 the next cycle.
